ibuf_ptr_ctrl: RTL and testbench
================================

IBUF_PTR_CTRL -- requirements
Module: ct_ifu_ibuf_ptr_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16, meaning number of half-word ibuf entries.
REQ-002 SHALL have parameter CREATE_MAX, default 8, meaning the most half-words created per cycle.
REQ-003 SHALL have parameter RETIRE_MAX, default 6, meaning the most half-words retired per cycle.
REQ-004 SHALL have port ibuf_entry_vld_clk  in  1  clock; reset cpurst_b, asynchronous, active-low; clock ibuf_entry_vld_clk.
REQ-005 SHALL have port cpurst_b  in  1  async active-low reset.
REQ-006 SHALL have port ibuf_flush  in  1  discard all entries.
REQ-007 SHALL have port ibuf_create_vld  in  1  create request.
REQ-008 SHALL have port ibuf_create_num  in  4  half-words to create, 0..CREATE_MAX.
REQ-009 SHALL have port ibuf_retire_vld  in  1  retire request.
REQ-010 SHALL have port ibuf_retire_num  in  3  half-words to retire, 0..RETIRE_MAX.
REQ-011 SHALL have port entry_create_x  out  ENTRY_NUM  per-entry create strobe (combinational).
REQ-012 SHALL have port entry_retire_x  out  ENTRY_NUM  per-entry retire strobe (combinational).
REQ-013 SHALL have port ibuf_create_ptr  out  ENTRY_NUM  one-hot write pointer (registered).
REQ-014 SHALL have port ibuf_retire_ptr  out  ENTRY_NUM  one-hot read pointer (registered).
REQ-015 SHALL have port ibuf_entry_cnt  out  5  valid entry count, 0..16 (registered).
REQ-016 SHALL have ports ibuf_empty, ibuf_full, ibuf_lack  out  1 each: cnt==0, cnt==16, free<CREATE_MAX.
REQ-017 SHALL have port ibuf_ptr_err  out  1  sticky protocol-violation flag.

Function
REQ-018 SHALL define free = ENTRY_NUM - ibuf_entry_cnt, using the registered count only.
REQ-019 SHALL define create_ok = ibuf_create_vld & !ibuf_flush & (create_num <= free); same-cycle retire does not add credit.
REQ-020 SHALL define retire_ok = ibuf_retire_vld & !ibuf_flush & (retire_num <= ibuf_entry_cnt).
REQ-021 SHALL drive entry_create_x with create_num consecutive bits starting at the create_ptr bit, wrapping 15->0, when create_ok; otherwise all zero.
REQ-022 SHALL drive entry_retire_x the same way from retire_ptr and retire_num when retire_ok; otherwise all zero.
REQ-023 SHALL rotate create_ptr left by create_num modulo ENTRY_NUM on the next edge when create_ok; otherwise hold.
REQ-024 SHALL rotate retire_ptr left by retire_num modulo ENTRY_NUM on the next edge when retire_ok; otherwise hold.
REQ-025 SHALL update cnt <= cnt + (create_ok?create_num:0) - (retire_ok?retire_num:0), with both terms applied in the same cycle.
REQ-026 SHALL compute empty, full and lack from the registered cnt, giving zero combinational paths from the request inputs.
REQ-027 SHALL give ibuf_flush priority over create and retire: next edge create_ptr=retire_ptr=16'h0001, cnt=0, strobes forced to zero in the flush cycle.
REQ-028 SHALL ignore a create with create_num>free, leaving pointers unchanged, and set ibuf_ptr_err on the next edge.
REQ-029 SHALL ignore a retire with retire_num>cnt and set ibuf_ptr_err on the next edge.
REQ-030 SHALL also set ibuf_ptr_err for create_num>CREATE_MAX or retire_num>RETIRE_MAX.
REQ-031 SHALL clear ibuf_ptr_err only by reset; flush does not clear it.
REQ-032 SHALL treat num==0 with vld=1 as a legal no-op: no strobes, no pointer change, no error.
REQ-033 SHALL keep both pointers one-hot at all times.
REQ-034 SHALL require the parent's gate enable to cover create_vld|retire_vld|ibuf_flush; the block relies on that and does no internal gating.

Reset
REQ-035 SHALL on cpurst_b low, asynchronously, set create_ptr=16'h0001, retire_ptr=16'h0001, cnt=0, empty=1, full=0, lack=0, ptr_err=0.
REQ-036 SHALL keep combinational strobes zero while in reset; an assertion mid-operation discards in-flight state with no recovery of counts.

Verification
REQ-037 SHALL verify: after reset, create 8 -> entry_create_x=16'h00FF; next cycle create_ptr=16'h0100, cnt=8, lack=0.
REQ-038 SHALL verify wrap: ptr=16'h4000, cnt=2, create 5 -> entry_create_x=16'h0007|16'hC000; next create_ptr=16'h0008, cnt=7.
REQ-039 SHALL verify simultaneous: cnt=10, create 6 + retire 4 -> both strobes active, cnt=12, lack=1.
REQ-040 SHALL verify overflow: cnt=12, create 5 -> no strobes, cnt stays 12, ptr_err=1 next edge and remains after flush.
REQ-041 SHALL verify flush with create 8 + retire 6 in the same cycle -> strobes 0; next edge both ptrs=16'h0001, cnt=0, empty=1.
REQ-042 SHALL verify full: fill to cnt=16 -> full=1; retire 6 then create 6 -> cnt=16, pointers equal, full=1.

Source files
------------

// File: rtl/ibuf_ptr_ctrl.sv
// Instruction buffer pointer control: one-hot create/retire pointers, valid-entry
// count, per-entry create/retire strobes and a sticky protocol-violation flag.
module ibuf_ptr_ctrl #(
    parameter int ENTRY_NUM  = 16,
    parameter int CREATE_MAX = 8,
    parameter int RETIRE_MAX = 6,
    localparam int CNT_W     = $clog2(ENTRY_NUM + 1)
) (
    input  logic                 ibuf_entry_vld_clk,
    input  logic                 cpurst_b,
    input  logic                 ibuf_flush,
    input  logic                 ibuf_create_vld,
    input  logic [3:0]           ibuf_create_num,
    input  logic                 ibuf_retire_vld,
    input  logic [2:0]           ibuf_retire_num,
    output logic [ENTRY_NUM-1:0] entry_create_x,
    output logic [ENTRY_NUM-1:0] entry_retire_x,
    output logic [ENTRY_NUM-1:0] ibuf_create_ptr,
    output logic [ENTRY_NUM-1:0] ibuf_retire_ptr,
    output logic [CNT_W-1:0]     ibuf_entry_cnt,
    output logic                 ibuf_empty,
    output logic                 ibuf_full,
    output logic                 ibuf_lack,
    output logic                 ibuf_ptr_err
);

    localparam logic [ENTRY_NUM-1:0] PTR_INIT = ENTRY_NUM'(1);

    logic [ENTRY_NUM-1:0] create_ptr_q, create_ptr_d;
    logic [ENTRY_NUM-1:0] retire_ptr_q, retire_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [31:0]          free;
    logic                 create_ok, retire_ok;
    logic                 create_bad, retire_bad;

    function automatic logic [ENTRY_NUM-1:0] rotl(input logic [ENTRY_NUM-1:0] v,
                                                  input int unsigned s);
        logic [2*ENTRY_NUM-1:0] t;
        t = {v, v} << (s % 32'(ENTRY_NUM));
        return t[2*ENTRY_NUM-1:ENTRY_NUM];
    endfunction

    // Credit comes from the registered count only; a same-cycle retire frees nothing yet.
    always_comb begin
        free       = 32'(ENTRY_NUM) - 32'(cnt_q);
        create_ok  = cpurst_b & ibuf_create_vld & ~ibuf_flush & (32'(ibuf_create_num) <= free);
        retire_ok  = cpurst_b & ibuf_retire_vld & ~ibuf_flush & (32'(ibuf_retire_num) <= 32'(cnt_q));
        create_bad = ibuf_create_vld & ~ibuf_flush &
                     ((32'(ibuf_create_num) > free) | (32'(ibuf_create_num) > 32'(CREATE_MAX)));
        retire_bad = ibuf_retire_vld & ~ibuf_flush &
                     ((32'(ibuf_retire_num) > 32'(cnt_q)) | (32'(ibuf_retire_num) > 32'(RETIRE_MAX)));
    end

    always_comb begin
        entry_create_x = '0;
        entry_retire_x = '0;
        for (int d = 0; d < ENTRY_NUM; d++) begin
            if (create_ok && d < int'(ibuf_create_num))
                entry_create_x = entry_create_x | rotl(create_ptr_q, 32'(d));
            if (retire_ok && d < int'(ibuf_retire_num))
                entry_retire_x = entry_retire_x | rotl(retire_ptr_q, 32'(d));
        end
    end

    always_comb begin
        create_ptr_d = create_ptr_q;
        retire_ptr_d = retire_ptr_q;
        cnt_d        = cnt_q;
        err_d        = err_q | create_bad | retire_bad;
        if (ibuf_flush) begin
            create_ptr_d = PTR_INIT;
            retire_ptr_d = PTR_INIT;
            cnt_d        = '0;
        end else begin
            if (create_ok)
                create_ptr_d = rotl(create_ptr_q, 32'(ibuf_create_num));
            if (retire_ok)
                retire_ptr_d = rotl(retire_ptr_q, 32'(ibuf_retire_num));
            cnt_d = CNT_W'(32'(cnt_q)
                           + (create_ok ? 32'(ibuf_create_num) : 32'd0)
                           - (retire_ok ? 32'(ibuf_retire_num) : 32'd0));
        end
    end

    always_ff @(posedge ibuf_entry_vld_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            create_ptr_q <= PTR_INIT;
            retire_ptr_q <= PTR_INIT;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            create_ptr_q <= create_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign ibuf_create_ptr = create_ptr_q;
    assign ibuf_retire_ptr = retire_ptr_q;
    assign ibuf_entry_cnt  = cnt_q;
    assign ibuf_empty      = (cnt_q == '0);
    assign ibuf_full       = (cnt_q == CNT_W'(ENTRY_NUM));
    assign ibuf_lack       = (free < 32'(CREATE_MAX));
    assign ibuf_ptr_err    = err_q;

endmodule

// File: tb/tb_ibuf_ptr_ctrl.sv
// Vector-table bench for ibuf_ptr_ctrl: strobes checked mid-cycle, registered
// state queued at drive time and compared after the following clock edge.
module tb_ibuf_ptr_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        flush, cvld, rvld;
    logic [3:0]  cnum;
    logic [2:0]  rnum;
    logic [15:0] create_x, retire_x, cptr, rptr;
    logic [4:0]  cnt;
    logic        empty, full, lack, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fl, cv;
        logic [3:0]  cn;
        logic        rv;
        logic [2:0]  rn;
        logic [15:0] cx, rx, cptr, rptr;
        logic [4:0]  cnt;
        logic        emp, ful, lck, err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    ibuf_ptr_ctrl dut (
        .ibuf_entry_vld_clk (clk),
        .cpurst_b           (rst_b),
        .ibuf_flush         (flush),
        .ibuf_create_vld    (cvld),
        .ibuf_create_num    (cnum),
        .ibuf_retire_vld    (rvld),
        .ibuf_retire_num    (rnum),
        .entry_create_x     (create_x),
        .entry_retire_x     (retire_x),
        .ibuf_create_ptr    (cptr),
        .ibuf_retire_ptr    (rptr),
        .ibuf_entry_cnt     (cnt),
        .ibuf_empty         (empty),
        .ibuf_full          (full),
        .ibuf_lack          (lack),
        .ibuf_ptr_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, cv, input logic [3:0] cn,
                                input logic rv, input logic [2:0] rn,
                                input logic [15:0] cx, rx, cp, rp,
                                input logic [4:0] c, input logic e, f, l, r);
        vec_t v;
        v.fl = fl; v.cv = cv; v.cn = cn; v.rv = rv; v.rn = rn;
        v.cx = cx; v.rx = rx; v.cptr = cp; v.rptr = rp;
        v.cnt = c; v.emp = e; v.ful = f; v.lck = l; v.err = r;
        return v;
    endfunction

    task automatic drive(input logic fl, cv, input logic [3:0] cn, input logic rv, input logic [2:0] rn);
        flush = fl; cvld = cv; cnum = cn; rvld = rv; rnum = rn;
    endtask

    task automatic check_state(input string tag, input vec_t e);
        chk({tag, " create_ptr"}, 32'(cptr), 32'(e.cptr));
        chk({tag, " retire_ptr"}, 32'(rptr), 32'(e.rptr));
        chk({tag, " cnt"},        32'(cnt),  32'(e.cnt));
        chk({tag, " empty"},      32'(empty), 32'(e.emp));
        chk({tag, " full"},       32'(full),  32'(e.ful));
        chk({tag, " lack"},       32'(lack),  32'(e.lck));
        chk({tag, " ptr_err"},    32'(err),   32'(e.err));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        vec_t e;
        rst_b = 1'b0;
        drive(0, 0, 0, 0, 0);

        //        fl cv cn rv rn  create_x  retire_x  cptr      rptr      cnt e  f  l  err
        tbl.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0001,  0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 0, 0, 16'h00FF, 16'h0000, 16'h0100, 16'h0001,  8, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 16'h0300, 16'h0000, 16'h0400, 16'h0001, 10, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6, 1, 4, 16'hFC00, 16'h000F, 16'h0001, 16'h0010, 12, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5, 0, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0010, 12, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 8, 1, 6, 16'h0000, 16'h0000, 16'h0001, 16'h0001,  0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0001, 16'h0001,  0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8, 0, 0, 16'h00FF, 16'h0000, 16'h0100, 16'h0001,  8, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 16'h3F00, 16'h0000, 16'h4000, 16'h0001, 14, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 6, 16'h0000, 16'h003F, 16'h4000, 16'h0040,  8, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 6, 16'h0000, 16'h0FC0, 16'h4000, 16'h1000,  2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 5, 0, 0, 16'hC007, 16'h0000, 16'h0008, 16'h1000,  7, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8, 0, 0, 16'h07F8, 16'h0000, 16'h0800, 16'h1000, 15, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0800, 16'h0000, 16'h1000, 16'h1000, 16, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 6, 16'h0000, 16'hF003, 16'h1000, 16'h0004, 10, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 6, 0, 0, 16'hF003, 16'h0000, 16'h0004, 16'h0004, 16, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 2, 1, 6, 16'h0000, 16'h00FC, 16'h0004, 16'h0100, 10, 0, 0, 1, 1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_state("reset", mk(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0001, 16'h0001, 0, 1, 0, 0, 0));
        rst_b = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].fl, tbl[i].cv, tbl[i].cn, tbl[i].rv, tbl[i].rn);
            #1;
            chk($sformatf("v%0d create_x", i), 32'(create_x), 32'(tbl[i].cx));
            chk($sformatf("v%0d retire_x", i), 32'(retire_x), 32'(tbl[i].rx));
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check_state($sformatf("v%0d", i), e);
            end
        end

        // Asynchronous reset mid-operation, with requests still applied.
        @(negedge clk);
        drive(0, 1, 8, 1, 6);
        #2;
        rst_b = 1'b0;
        #1;
        check_state("async_rst", mk(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0001, 16'h0001, 0, 1, 0, 0, 0));
        chk("async_rst create_x", 32'(create_x), 32'h0);
        chk("async_rst retire_x", 32'(retire_x), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst_b = 1'b1;

        // Retire from an empty buffer is dropped and flagged.
        @(negedge clk);
        drive(0, 0, 0, 1, 1);
        #1;
        chk("under retire_x", 32'(retire_x), 32'h0);
        @(posedge clk);
        #1;
        check_state("under", mk(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0001, 16'h0001, 0, 1, 0, 0, 1));

        // Create larger than CREATE_MAX is flagged.
        pulse_reset();
        #1;
        chk("pre_cmax ptr_err", 32'(err), 32'h0);
        @(negedge clk);
        drive(0, 1, 9, 0, 0);
        @(posedge clk);
        #1;
        chk("cmax ptr_err", 32'(err), 32'h1);

        // Retire larger than RETIRE_MAX is flagged.
        pulse_reset();
        @(negedge clk);
        drive(0, 1, 8, 0, 0);
        @(posedge clk);
        #1;
        chk("rmax_fill cnt", 32'(cnt), 32'd8);
        chk("rmax_fill ptr_err", 32'(err), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 1, 7);
        @(posedge clk);
        #1;
        chk("rmax ptr_err", 32'(err), 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
